// File: rtl/trig_pkg.sv
// Shared types and channel-config bit positions for the multi-channel trigger engine.
// The per-channel match equation lives here so every slice evaluates it the same way.
package trig_pkg;

    localparam int CFG_DC   = 0;
    localparam int CFG_LOW  = 1;
    localparam int CFG_HIGH = 2;
    localparam int CFG_NEG  = 3;
    localparam int CFG_POS  = 4;

    typedef logic [4:0] chan_cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        QUAL,
        TRIGD
    } trig_state_t;

    function automatic logic chan_match(
        input chan_cfg_t cfg,
        input logic      h_q,
        input logic      l_q,
        input logic      neg_seen,
        input logic      pos_seen
    );
        return cfg[CFG_DC]
             | (cfg[CFG_LOW]  & ~l_q)
             | (cfg[CFG_HIGH] &  h_q)
             | (cfg[CFG_NEG]  &  neg_seen)
             | (cfg[CFG_POS]  &  pos_seen);
    endfunction

endpackage

// File: rtl/chan_trig_slice.sv
// One trigger channel: comparator sample registers, sticky edge latches and the
// registered match bit. Edges are found against the previous sample, all on clk.
module chan_trig_slice
    import trig_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      armed,
    input  chan_cfg_t cfg,
    input  logic      hff5,
    input  logic      lff5,
    output logic      match
);

    logic h_q;
    logic l_q;
    logic pos_seen;
    logic neg_seen;
    logic pos_evt;
    logic neg_evt;

    // Rising high-comparator and falling low-comparator are the interesting edges.
    assign pos_evt = hff5 & ~h_q;
    assign neg_evt = ~lff5 & l_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q      <= 1'b0;
            l_q      <= 1'b0;
            pos_seen <= 1'b0;
            neg_seen <= 1'b0;
            match    <= 1'b0;
        end else begin
            h_q      <= hff5;
            l_q      <= lff5;
            pos_seen <= armed & (pos_seen | pos_evt);
            neg_seen <= armed & (neg_seen | neg_evt);
            match    <= chan_match(cfg, h_q, l_q, neg_seen, pos_seen);
        end
    end

endmodule

// File: rtl/multi_chan_trigger.sv
// N-channel trigger engine: per-channel slices, AND/OR combine, min-width qualification,
// sticky trigger flag. Optional trigger timestamp enabled by defining TRIG_TIMESTAMP_EN.
//
// state | meaning
// IDLE  | disarmed, all trigger state cleared
// ARMED | armed, waiting for the combined match
// QUAL  | combined match present, counting toward min_width
// TRIGD | triggered; sticky until armed drops
module multi_chan_trigger
    import trig_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int QUAL_W = 8,
    parameter int TS_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                armed,
    input  logic [5*NUM_CH-1:0] trig_cfg,
    input  logic                combine_or,
    input  logic [QUAL_W-1:0]   min_width,
    input  logic [NUM_CH-1:0]   ch_hff5,
    input  logic [NUM_CH-1:0]   ch_lff5,
    output logic                trig_pulse,
    output logic                triggered,
    output logic [NUM_CH-1:0]   ch_match,
    output logic [TS_W-1:0]     trig_ts
);

    trig_state_t       state;
    trig_state_t       state_nxt;
    logic [QUAL_W-1:0] qcnt;
    logic [QUAL_W-1:0] qcnt_nxt;
    logic [QUAL_W-1:0] qual_last;
    logic              combined;
    logic              pulse_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        chan_trig_slice u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .armed (armed),
            .cfg   (trig_cfg[5*i +: 5]),
            .hff5  (ch_hff5[i]),
            .lff5  (ch_lff5[i]),
            .match (ch_match[i])
        );
    end

    assign combined = combine_or ? (|ch_match) : (&ch_match);

    // Count of combined cycles needed beyond the first; min_width of 0 behaves as 1.
    assign qual_last = (min_width == '0) ? '0 : (min_width - QUAL_W'(1));

    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        case (state)
            IDLE: begin
                qcnt_nxt = '0;
                if (armed) state_nxt = ARMED;
            end
            ARMED: begin
                qcnt_nxt = '0;
                if (combined) begin
                    if (qual_last == '0) begin
                        state_nxt = TRIGD;
                    end else begin
                        state_nxt = QUAL;
                        qcnt_nxt  = QUAL_W'(1);
                    end
                end
            end
            QUAL: begin
                if (!combined) begin
                    state_nxt = ARMED;
                    qcnt_nxt  = '0;
                end else if (qcnt >= qual_last) begin
                    state_nxt = TRIGD;
                end else if (qcnt != '1) begin
                    qcnt_nxt = qcnt + QUAL_W'(1);
                end
            end
            TRIGD: begin
                state_nxt = TRIGD;
            end
            default: begin
                state_nxt = IDLE;
                qcnt_nxt  = '0;
            end
        endcase
        if (!armed) begin
            state_nxt = IDLE;
            qcnt_nxt  = '0;
        end
    end

    assign pulse_nxt = (state_nxt == TRIGD) && (state != TRIGD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            qcnt       <= '0;
            trig_pulse <= 1'b0;
            triggered  <= 1'b0;
        end else begin
            state      <= state_nxt;
            qcnt       <= qcnt_nxt;
            trig_pulse <= pulse_nxt;
            triggered  <= (state_nxt == TRIGD);
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    // Captures the counter value seen during the trig_pulse cycle; survives disarm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt  <= '0;
            trig_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (pulse_nxt) trig_ts <= ts_cnt + TS_W'(1);
        end
    end
`else
    assign trig_ts = '0;
`endif

endmodule

// File: tb/tb_multi_chan_trigger.sv
// Directed bench for multi_chan_trigger: stimulus queues expected trigger pulses,
// a negedge monitor pops and compares them whenever trig_pulse is seen.
module tb_multi_chan_trigger;

    localparam int NUM_CH = 5;
    localparam int QUAL_W = 8;
    localparam int TS_W   = 16;

    localparam logic [4:0] C_OFF  = 5'b00000;
    localparam logic [4:0] C_DC   = 5'b00001;
    localparam logic [4:0] C_LOW  = 5'b00010;
    localparam logic [4:0] C_HIGH = 5'b00100;
    localparam logic [4:0] C_NEG  = 5'b01000;
    localparam logic [4:0] C_POS  = 5'b10000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                armed = 1'b0;
    logic [5*NUM_CH-1:0] trig_cfg = '0;
    logic                combine_or = 1'b0;
    logic [QUAL_W-1:0]   min_width = 8'd1;
    logic [NUM_CH-1:0]   ch_hff5 = '0;
    logic [NUM_CH-1:0]   ch_lff5 = '1;
    logic                trig_pulse;
    logic                triggered;
    logic [NUM_CH-1:0]   ch_match;
    logic [TS_W-1:0]     trig_ts;

    multi_chan_trigger #(
        .NUM_CH (NUM_CH),
        .QUAL_W (QUAL_W),
        .TS_W   (TS_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .armed      (armed),
        .trig_cfg   (trig_cfg),
        .combine_or (combine_or),
        .min_width  (min_width),
        .ch_hff5    (ch_hff5),
        .ch_lff5    (ch_lff5),
        .trig_pulse (trig_pulse),
        .triggered  (triggered),
        .ch_match   (ch_match),
        .trig_ts    (trig_ts)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) if (rst_n) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        string name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic [TS_W-1:0] exp_ts;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input string name, input int offset);
        exp_q.push_back('{cyc + offset, name});
    endtask

    always @(negedge clk) begin
        if (rst_n && trig_pulse) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=pulse at cycle %0d required=no pulse", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
                check({mon_e.name, "_triggered"}, 32'(triggered), 32'd1);
`ifdef TRIG_TIMESTAMP_EN
                exp_ts = cyc[TS_W-1:0];
`else
                exp_ts = '0;
`endif
                check({mon_e.name, "_ts"}, 32'(trig_ts), 32'(exp_ts));
            end
        end
    end

    initial begin
        #12;
        check("rst_trig_pulse", 32'(trig_pulse), 32'd0);
        check("rst_triggered", 32'(triggered), 32'd0);
        check("rst_ch_match", 32'(ch_match), 32'd0);
        check("rst_trig_ts", 32'(trig_ts), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // ch0 rising edge, AND, min_width 1
        trig_cfg = {C_DC, C_DC, C_DC, C_DC, C_POS};
        combine_or = 1'b0;
        min_width = 8'd1;
        armed = 1'b1;
        tick(3);
        check("s1_match_before_edge", 32'(ch_match), 32'h1E);
        ch_hff5[0] = 1'b1;
        expect_at("s1_pos", 3);
        tick(6);
        check("s1_triggered", 32'(triggered), 32'd1);
        ch_hff5[0] = 1'b0;
        tick(3);
        check("s1_sticky", 32'(triggered), 32'd1);
        armed = 1'b0;
        tick(2);
        check("s1_disarm_clear", 32'(triggered), 32'd0);

        // ch1 low level with min_width 4: 3 cycles too short, 4 cycles fires
        trig_cfg = {C_DC, C_DC, C_DC, C_LOW, C_DC};
        min_width = 8'd4;
        armed = 1'b1;
        tick(3);
        ch_lff5[1] = 1'b0;
        tick(3);
        ch_lff5[1] = 1'b1;
        tick(8);
        check("s2_short_no_trig", 32'(triggered), 32'd0);
        ch_lff5[1] = 1'b0;
        expect_at("s2_width4", 6);
        tick(4);
        ch_lff5[1] = 1'b1;
        tick(6);
        check("s2_triggered", 32'(triggered), 32'd1);
        armed = 1'b0;
        tick(2);

        // ch0 POS then ch2 NEG ten cycles later, AND
        trig_cfg = {C_DC, C_DC, C_NEG, C_DC, C_POS};
        min_width = 8'd1;
        armed = 1'b1;
        tick(3);
        ch_hff5[0] = 1'b1;
        tick(2);
        ch_hff5[0] = 1'b0;
        tick(8);
        check("s3_pos_only", 32'(triggered), 32'd0);
        ch_lff5[2] = 1'b0;
        expect_at("s3_pos_then_neg", 3);
        tick(1);
        ch_lff5[2] = 1'b1;
        tick(5);
        check("s3_match_all", 32'(ch_match), 32'h1F);
        check("s3_triggered", 32'(triggered), 32'd1);
        armed = 1'b0;
        tick(3);
        check("s3_latches_cleared", 32'(ch_match), 32'h1A);
        check("s3_disarm_clear", 32'(triggered), 32'd0);

        // edge while disarmed must not be remembered
        trig_cfg = {C_DC, C_DC, C_DC, C_DC, C_POS};
        ch_hff5[0] = 1'b1;
        tick(3);
        armed = 1'b1;
        tick(8);
        check("s4_edge_while_disarmed", 32'(triggered), 32'd0);
        ch_hff5[0] = 1'b0;
        armed = 1'b0;
        tick(2);

        // forced trigger, disarm mid-qualification, then min_width boundaries
        trig_cfg = {C_DC, C_DC, C_DC, C_DC, C_DC};
        min_width = 8'd8;
        tick(2);
        armed = 1'b1;
        tick(4);
        check("s4_in_qual", 32'(triggered), 32'd0);
        armed = 1'b0;
        tick(10);
        check("s4_qual_abort", 32'(triggered), 32'd0);
        armed = 1'b1;
        expect_at("s4_forced_mw8", 9);
        tick(12);
        check("s4_forced_triggered", 32'(triggered), 32'd1);
        armed = 1'b0;
        tick(2);
        min_width = 8'd0;
        armed = 1'b1;
        expect_at("s4_forced_mw0", 2);
        tick(4);
        armed = 1'b0;
        tick(2);
        min_width = 8'd2;
        armed = 1'b1;
        expect_at("s4_forced_mw2", 3);
        tick(5);
        armed = 1'b0;
        tick(2);

        // OR vs AND with disabled channels
        trig_cfg = {C_OFF, C_HIGH, C_OFF, C_OFF, C_OFF};
        combine_or = 1'b1;
        min_width = 8'd1;
        armed = 1'b1;
        tick(3);
        check("s5_match_none", 32'(ch_match), 32'd0);
        ch_hff5[3] = 1'b1;
        expect_at("s5_or_high", 3);
        tick(5);
        check("s5_or_triggered", 32'(triggered), 32'd1);
        armed = 1'b0;
        ch_hff5[3] = 1'b0;
        tick(2);
        combine_or = 1'b0;
        armed = 1'b1;
        tick(2);
        ch_hff5[3] = 1'b1;
        tick(10);
        check("s5_and_blocked", 32'(triggered), 32'd0);
        check("s5_and_match", 32'(ch_match), 32'h08);
        armed = 1'b0;
        ch_hff5[3] = 1'b0;
        tick(2);

        check("all_expected_pulses_seen", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
